// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch PC generation, IF/ID register and branch-redirect squash control
//
// Parameters:
//   RESET_PC      - PC loaded on reset
//   SQUASH_CYCLES - consecutive FlushD cycles per redirect (1..4)
// Optional feature macro:
//   FETCH_REDIRECT_COUNT_EN - when defined, RedirectCount counts accepted redirects
//                             (saturating); otherwise RedirectCount is tied to 0
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   PCsrcE, PCtargetE    - redirect request and target from Execute
//   StallF, StallD       - hold requests for the PC and the IF/ID register
//   InstrF               - instruction fetched at PCF
//   PCF                  - current fetch PC
//   InstrD, PCD, PCPlus4D, ValidD - IF/ID register contents
//   FlushD, FlushE       - IF/ID squash in progress, ID/EX squash request
//   RedirectCount        - number of accepted redirects

module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          SQUASH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCsrcE,
    input  logic [31:0] PCtargetE,
    input  logic        StallF,
    input  logic        StallD,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [31:0] RedirectCount
);

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [2:0]  CNT_RELOAD  = 3'(SQUASH_CYCLES - 1);
    localparam logic [0:0]  ST_RUN      = 1'b0;
    localparam logic [0:0]  ST_SQUASH   = 1'b1;

    logic [31:0] r_pcf;
    logic [31:0] r_instrd;
    logic [31:0] r_pcd;
    logic [31:0] r_pcplus4d;
    logic        r_validd;
    logic [2:0]  r_cnt;

    logic [31:0] w_target;
    logic [31:0] w_pcf_plus4;
    logic [31:0] w_next_pc;
    logic [0:0]  w_state;
    logic        w_flushd;

    // Targets are forced word-aligned; the low bits are masked rather than
    // sliced so the full target bus is consumed.
    assign w_target    = PCtargetE & 32'hFFFF_FFFC;
    assign w_pcf_plus4 = r_pcf + 32'd4;

    always_comb begin
        w_next_pc = w_pcf_plus4;
        if (PCsrcE) begin
            w_next_pc = w_target;
        end else if (StallF) begin
            w_next_pc = r_pcf;
        end
    end

    assign w_state  = (r_cnt != 3'd0) ? ST_SQUASH : ST_RUN;
    // The redirect cycle itself is flushed combinationally; the counter only
    // covers the extra cycles after it.
    assign w_flushd = PCsrcE | (w_state == ST_SQUASH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcf <= RESET_PC;
        end else begin
            r_pcf <= w_next_pc;
        end
    end

    // A new redirect restarts the count even while already squashing, so the
    // latest redirect always gets its full squash window. Stalls never freeze it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (PCsrcE) begin
            r_cnt <= CNT_RELOAD;
        end else if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // Flush has priority over stall: a squashed slot must not be held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instrd   <= NOP_INSTR;
            r_pcd      <= 32'd0;
            r_pcplus4d <= 32'd0;
            r_validd   <= 1'b0;
        end else if (w_flushd) begin
            r_instrd   <= NOP_INSTR;
            r_pcd      <= 32'd0;
            r_pcplus4d <= 32'd0;
            r_validd   <= 1'b0;
        end else if (!StallD) begin
            r_instrd   <= InstrF;
            r_pcd      <= r_pcf;
            r_pcplus4d <= w_pcf_plus4;
            r_validd   <= 1'b1;
        end
    end

`ifdef FETCH_REDIRECT_COUNT_EN
    logic [31:0] r_redirect_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_count <= 32'd0;
        end else if (PCsrcE && (r_redirect_count != 32'hFFFF_FFFF)) begin
            r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign RedirectCount = r_redirect_count;
`else
    assign RedirectCount = 32'd0;
`endif

    assign PCF      = r_pcf;
    assign InstrD   = r_instrd;
    assign PCD      = r_pcd;
    assign PCPlus4D = r_pcplus4d;
    assign ValidD   = r_validd;
    assign FlushD   = w_flushd;
    assign FlushE   = PCsrcE;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - self-checking bench for fetch_redirect_ctrl (SQUASH_CYCLES 1 and 3)

module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        psrc;
    logic [31:0] tgt;
    logic        sf;
    logic        sd;
    logic [31:0] instrf   [2];
    logic [31:0] pcf      [2];
    logic [31:0] instrd   [2];
    logic [31:0] pcd      [2];
    logic [31:0] pcp4     [2];
    logic        validd   [2];
    logic        flushd   [2];
    logic        flushe   [2];
    logic [31:0] rcnt     [2];

    int nchk = 0;
    int nerr = 0;
    int fl_cnt = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(.RESET_PC(32'h0), .SQUASH_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .PCsrcE(psrc), .PCtargetE(tgt), .StallF(sf), .StallD(sd),
        .InstrF(instrf[0]), .PCF(pcf[0]), .InstrD(instrd[0]), .PCD(pcd[0]),
        .PCPlus4D(pcp4[0]), .ValidD(validd[0]), .FlushD(flushd[0]), .FlushE(flushe[0]),
        .RedirectCount(rcnt[0])
    );

    fetch_redirect_ctrl #(.RESET_PC(32'h0), .SQUASH_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .PCsrcE(psrc), .PCtargetE(tgt), .StallF(sf), .StallD(sd),
        .InstrF(instrf[1]), .PCF(pcf[1]), .InstrD(instrd[1]), .PCD(pcd[1]),
        .PCPlus4D(pcp4[1]), .ValidD(validd[1]), .FlushD(flushd[1]), .FlushE(flushe[1]),
        .RedirectCount(rcnt[1])
    );

    // Reference model: squash is expressed as "cycles since the latest redirect".
    int          sqn [2] = '{1, 3};
    logic [31:0] m_pc     [2];
    logic [31:0] m_instrd [2];
    logic [31:0] m_pcd    [2];
    logic [31:0] m_pcp4   [2];
    logic        m_valid  [2];
    int          m_last   [2];
    longint      m_cnt    [2];
    int          m_cyc = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc * 32'd7) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic m_flush(input int k);
        int age;
        age = m_cyc - m_last[k];
        return psrc || (age >= 1 && age < sqn[k]);
    endfunction

    function automatic logic [31:0] m_rcnt(input int k);
`ifdef FETCH_REDIRECT_COUNT_EN
        return (m_cnt[k] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_cnt[k][31:0];
`else
        return (m_cnt[k] < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic refresh_instrf();
        for (int k = 0; k < 2; k++) instrf[k] = instr_of(m_pc[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]     = 32'h0;
            m_instrd[k] = 32'h0000_0013;
            m_pcd[k]    = 32'h0;
            m_pcp4[k]   = 32'h0;
            m_valid[k]  = 1'b0;
            m_last[k]   = -1000;
            m_cnt[k]    = 0;
        end
    endtask

    task automatic model_step();
        logic fl [2];
        for (int k = 0; k < 2; k++) fl[k] = m_flush(k);
        for (int k = 0; k < 2; k++) begin
            if (fl[k]) begin
                m_instrd[k] = 32'h0000_0013;
                m_pcd[k]    = 32'h0;
                m_pcp4[k]   = 32'h0;
                m_valid[k]  = 1'b0;
            end else if (!sd) begin
                m_instrd[k] = instrf[k];
                m_pcd[k]    = m_pc[k];
                m_pcp4[k]   = m_pc[k] + 32'd4;
                m_valid[k]  = 1'b1;
            end
            if (psrc) begin
                m_pc[k]   = {tgt[31:2], 2'b00};
                m_last[k] = m_cyc;
                m_cnt[k]  = m_cnt[k] + 1;
            end else if (!sf) begin
                m_pc[k] = m_pc[k] + 32'd4;
            end
        end
        m_cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pcf[%0d]", k),    pcf[k],    m_pc[k]);
            chk($sformatf("instrd[%0d]", k), instrd[k], m_instrd[k]);
            chk($sformatf("pcd[%0d]", k),    pcd[k],    m_pcd[k]);
            chk($sformatf("pcp4d[%0d]", k),  pcp4[k],   m_pcp4[k]);
            chk($sformatf("validd[%0d]", k), 32'(validd[k]), 32'(m_valid[k]));
            chk($sformatf("flushd[%0d]", k), 32'(flushd[k]), 32'(m_flush(k)));
            chk($sformatf("flushe[%0d]", k), 32'(flushe[k]), 32'(psrc));
            chk($sformatf("rcnt[%0d]", k),   rcnt[k],   m_rcnt(k));
        end
    endtask

    // One cycle: compare on the falling edge, advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        if (flushd[1]) fl_cnt++;
        @(posedge clk);
        if (!rst) model_step();
        #1;
        refresh_instrf();
    endtask

    task automatic set_in(input logic p, input logic [31:0] t, input logic s_f, input logic s_d);
        psrc = p; tgt = t; sf = s_f; sd = s_d;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        model_reset();
        refresh_instrf();
        #1;
        chk("reset_pcf", pcf[0], 32'h0);
        chk("reset_instrd", instrd[0], 32'h0000_0013);
        chk("reset_validd", 32'(validd[0]), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Sequential fetch from reset
        tick();
        chk("seq_pcf_4", pcf[0], 32'h4);
        tick();
        chk("seq_pcf_8", pcf[0], 32'h8);
        chk("seq_validd", 32'(validd[0]), 32'h1);
        chk("seq_pcd_lag", pcd[0], 32'h4);
        tick();
        tick();
        chk("seq_pcf_10", pcf[0], 32'h10);

        // Single redirect, one bubble
        set_in(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("redir_pcf", pcf[0], 32'h100);
        chk("redir_bubble_valid", 32'(validd[0]), 32'h0);
        chk("redir_bubble_nop", instrd[0], 32'h0000_0013);
        tick();
        chk("redir_pcd", pcd[0], 32'h100);
        chk("redir_valid_back", 32'(validd[0]), 32'h1);
        tick(); tick(); tick();

        // Back-to-back redirects with SQUASH_CYCLES=3
        fl_cnt = 0;
        set_in(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        chk("b2b_pcf", pcf[1], 32'h200);
        for (int i = 0; i < 5; i++) tick();
        chk("b2b_flush_len", 32'(fl_cnt), 32'd4);

        // Redirect beats both stalls; IF/ID flushed not held
        set_in(1'b1, 32'h300, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall_redir_pcf", pcf[0], 32'h300);
        chk("stall_redir_valid", 32'(validd[0]), 32'h0);
        chk("stall_redir_pcd", pcd[0], 32'h0);

        // Alignment and wrap
        set_in(1'b1, 32'h103, 1'b0, 1'b0);
        tick();
        chk("align_pcf", pcf[0], 32'h100);
        set_in(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap_pre", pcf[0], 32'hFFFF_FFFC);
        tick();
        chk("wrap_pcf", pcf[0], 32'h0);
        tick(); tick(); tick();

        // Reset mid-squash
        set_in(1'b1, 32'h400, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_pcf", pcf[1], 32'h0);
        chk("rst_mid_flush", 32'(flushd[1]), 32'h0);
        chk("rst_mid_valid", 32'(validd[1]), 32'h0);
        chk("rst_mid_instrd", instrd[1], 32'h0000_0013);
        tick();
        rst = 1'b0;
        refresh_instrf();

        // Five redirects then reset
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h40 * (i + 1), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_REDIRECT_COUNT_EN
        chk("rcnt_five", rcnt[0], 32'd5);
`else
        chk("rcnt_tied", rcnt[0], 32'd0);
`endif
        rst = 1'b1;
        model_reset();
        #1;
        chk("rcnt_cleared", rcnt[0], 32'd0);
        tick();
        rst = 1'b0;
        refresh_instrf();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(5) == 0), $urandom, ($urandom_range(3) == 0),
                   ($urandom_range(3) == 0));
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(199) == 0) begin
                rst = 1'b1;
                model_reset();
                refresh_instrf();
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
